// File: rtl/write_back_lsu_stage_pkg.sv
// Shared state, code and holding-register definitions for the writeback / load stage.
package write_back_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT
  } wb_state_e;

  localparam logic [1:0] WB_BYTE = 2'b00;
  localparam logic [1:0] WB_HALF = 2'b01;
  localparam logic [1:0] WB_WORD = 2'b10;
  localparam logic [1:0] WB_DBL  = 2'b11;

  localparam logic [1:0] EXC_MISAL  = 2'b01;
  localparam logic [1:0] EXC_TMO    = 2'b10;
  localparam logic [1:0] EXC_BUSERR = 2'b11;

  localparam int RSLT_W = 64;

  // Sized for the widest configuration; RV32 simply ignores the upper half.
  typedef struct packed {
    logic [4:0]        rd;
    logic [RSLT_W-1:0] result;
    logic              load;
    logic [2:0]        addr;
    logic [1:0]        width;
    logic              isUnsigned;
    logic              fault;
  } hold_reg_t;

  // Doubleword access has no legal encoding without RV64.
  function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] width,
                                      input logic rv64);
    logic bad;
    case (width)
      WB_HALF: bad = addr[0];
      WB_WORD: bad = |addr[1:0];
      WB_DBL:  bad = !rv64 || (|addr);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/write_back_lsu_stage_load_align_ext.sv
// Selects the addressed byte lane of a load response and sign/zero-extends it to XLEN.
module load_align_ext #(
  parameter  int RV64 = 0,
  localparam int XLEN = 32 * (1 + RV64),
  localparam int AW   = 2 + RV64
) (
  input  logic [XLEN-1:0] i_dat,
  input  logic [AW-1:0]   i_addr,
  input  logic [1:0]      i_width,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_dat
);
  import write_back_pkg::*;

  logic [XLEN-1:0] w_lane;

  assign w_lane = i_dat >> {i_addr, 3'b000};

  // A full-width field passes through, which also makes iUnsigned a no-op there.
  always_comb begin
    o_dat = w_lane;
    case (i_width)
      WB_BYTE: begin
        if (i_unsigned) o_dat = XLEN'(w_lane[7:0]);
        else            o_dat = XLEN'($signed(w_lane[7:0]));
      end
      WB_HALF: begin
        if (i_unsigned) o_dat = XLEN'(w_lane[15:0]);
        else            o_dat = XLEN'($signed(w_lane[15:0]));
      end
      WB_WORD: begin
        if (i_unsigned) o_dat = XLEN'(w_lane[31:0]);
        else            o_dat = XLEN'($signed(w_lane[31:0]));
      end
      default: o_dat = w_lane;
    endcase
  end

endmodule

// File: rtl/write_back_lsu_stage.sv
// Writeback stage with a load-response wait state, alignment, fault detection and forwarding.
module write_back_lsu_stage #(
  parameter  int RV64        = 0,
  parameter  int TIMEOUT_CYC = 255,
  localparam int XLEN        = 32 * (1 + RV64),
  localparam int AW          = 2 + RV64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iVld,
  output logic            oRdy,
  input  logic [4:0]      iRd,
  input  logic [XLEN-1:0] iIntRslt,
  input  logic            iLoad,
  input  logic [AW-1:0]   iMemAddr,
  input  logic [1:0]      iMemWidth,
  input  logic            iUnsigned,
  input  logic            iMemVld,
  input  logic            iMemErr,
  input  logic [XLEN-1:0] iMemDat,
  output logic            oWbVld,
  output logic [4:0]      oWbRd,
  output logic [XLEN-1:0] oWbDat,
  output logic            oFwdVld,
  output logic [4:0]      oFwdRd,
  output logic [XLEN-1:0] oFwdDat,
  output logic            oFwdPend,
  output logic [4:0]      oFwdPendRd,
  output logic            oExcVld,
  output logic [1:0]      oExcCause
);
  import write_back_pkg::*;

  wb_state_e       r_state;
  wb_state_e       w_nextState;
  hold_reg_t       r_hold;
  logic [15:0]     r_cnt;
  logic            w_accept;
  logic            w_tmoHit;
  logic            w_misal;
  logic [2:0]      w_addrIn;
  logic [XLEN-1:0] w_ldDat;
  logic            w_unused;

  assign w_addrIn = 3'(iMemAddr);
  assign w_misal  = iLoad && misaligned(w_addrIn, iMemWidth, RV64 != 0);
  assign w_tmoHit = (r_cnt == 16'(TIMEOUT_CYC - 1));
  assign oRdy     = (r_state != WAIT) || iMemVld || w_tmoHit;
  assign w_accept = iVld && oRdy;
  assign w_unused = ^{r_hold.result, r_hold.addr, r_hold.load};

  load_align_ext #(.RV64(RV64)) u_align (
    .i_dat      (iMemDat),
    .i_addr     (r_hold.addr[AW-1:0]),
    .i_width    (r_hold.width),
    .i_unsigned (r_hold.isUnsigned),
    .o_dat      (w_ldDat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_hold <= '{rd: iRd, result: RSLT_W'(iIntRslt), load: iLoad, addr: w_addrIn,
                    width: iMemWidth, isUnsigned: iUnsigned, fault: w_misal};
        r_cnt  <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // A response in the timeout cycle is checked first so it wins over the timeout.
  always_comb begin
    w_nextState = r_state;
    oWbVld      = 1'b0;
    oWbRd       = '0;
    oWbDat      = '0;
    oFwdPend    = 1'b0;
    oFwdPendRd  = '0;
    oExcVld     = 1'b0;
    oExcCause   = '0;
    case (r_state)
      HOLD: begin
        if (r_hold.fault) begin
          oExcVld   = 1'b1;
          oExcCause = EXC_MISAL;
        end else begin
          oWbVld = |r_hold.rd;
          oWbRd  = r_hold.rd;
          oWbDat = r_hold.result[XLEN-1:0];
        end
        w_nextState = IDLE;
      end
      WAIT: begin
        oFwdPend   = 1'b1;
        oFwdPendRd = r_hold.rd;
        if (iMemVld) begin
          if (iMemErr) begin
            oExcVld   = 1'b1;
            oExcCause = EXC_BUSERR;
          end else begin
            oWbVld = |r_hold.rd;
            oWbRd  = r_hold.rd;
            oWbDat = w_ldDat;
          end
          w_nextState = IDLE;
        end else if (w_tmoHit) begin
          oExcVld     = 1'b1;
          oExcCause   = EXC_TMO;
          w_nextState = IDLE;
        end
      end
      default: ;
    endcase
    if (w_accept) w_nextState = (iLoad && !w_misal) ? WAIT : HOLD;
  end

  assign oFwdVld = oWbVld;
  assign oFwdRd  = oWbRd;
  assign oFwdDat = oWbDat;

endmodule
